// File: rtl/aes_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_dec_round_ctrl (with helper aes_mixcolumns_inv)
// Brief    : Iterative AES inverse-cipher round sequencer. One round per
//            clock over a shared datapath: InvShiftRows (wiring), external
//            inverse S-box bank, AddRoundKey XOR, InvMixColumns.
// Revision : 1.0 - initial release
// ============================================================================

// InvMixColumns over a full 128-bit column-major state
module aes_mixcolumns_inv (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplies by 0x09/0x0b/0x0d/0x0e built from xtime chains
  function automatic logic [7:0] m9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction
  function automatic logic [7:0] m11(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction
  function automatic logic [7:0] m13(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction
  function automatic logic [7:0] m14(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = data_i[127-32*c    -: 8];
    assign a1 = data_i[127-32*c-8  -: 8];
    assign a2 = data_i[127-32*c-16 -: 8];
    assign a3 = data_i[127-32*c-24 -: 8];
    assign data_o[127-32*c    -: 8] = m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3);
    assign data_o[127-32*c-8  -: 8] = m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3);
    assign data_o[127-32*c-16 -: 8] = m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3);
    assign data_o[127-32*c-24 -: 8] = m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3);
  end

endmodule

module aes_dec_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ct_i,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_i,
  output logic [127:0] isb_o,
  input  logic [127:0] isb_i,
  output logic         busy,
  output logic [127:0] pt_o,
  output logic         pt_valid,
  input  logic         pt_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  localparam logic [3:0] C_NR    = 4'(NR);
  localparam logic [3:0] C_NR_M1 = 4'(NR - 1);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] ark;
  logic [127:0] imc;

  // InvShiftRows: row r rotated right by r bytes, out(r,c) = in(r,(c-r) mod 4)
  for (genvar r = 0; r < 4; r++) begin : g_isr_row
    for (genvar c = 0; c < 4; c++) begin : g_isr_col
      assign isb_o[127-8*(4*c+r) -: 8] = st_q[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end

  assign ark = isb_i ^ rk_i;

  aes_mixcolumns_inv u_imc (
    .data_i (ark),
    .data_o (imc)
  );

  assign busy     = (fsm_q != IDLE);
  assign pt_valid = (fsm_q == DONE);
  assign pt_o     = pt_q;

  // Next-state, round-key index and datapath load selection
  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    rnd_d  = rnd_q;
    pt_d   = pt_q;
    rk_idx = C_NR;
    case (fsm_q)
      IDLE: begin
        rk_idx = C_NR;
        if (start) begin
          st_d  = ct_i ^ rk_i;
          rnd_d = C_NR_M1;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        rk_idx = rnd_q;
        st_d   = imc;
        if (rnd_q == 4'd1) begin
          fsm_d = FINAL;
        end else begin
          rnd_d = 4'(rnd_q - 4'd1);
        end
      end
      FINAL: begin
        rk_idx = 4'd0;
        pt_d   = ark;
        fsm_d  = DONE;
      end
      DONE: begin
        // Key store is idle here; index parked at the last key used
        rk_idx = 4'd0;
        if (pt_ready) begin
          fsm_d = IDLE;
        end
      end
    endcase
  end

  // State, round counter and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      st_q  <= '0;
      rnd_q <= '0;
      pt_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      rnd_q <= rnd_d;
      pt_q  <= pt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_dec_round_ctrl
// Brief    : Bench for aes_dec_round_ctrl, NR=10 and NR=14 instances with a
//            key-store model, inverse S-box model and byte-level AES model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_dec_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start10, start14, pt_ready;
  logic [127:0] ct;
  logic [3:0]   rk_idx10, rk_idx14;
  logic [127:0] rk10, rk14, isbo10, isbo14, isbi10, isbi14, pt10, pt14;
  logic         busy10, busy14, v10, v14;

  logic [7:0]   sbox [0:255];
  logic [7:0]   isbox[0:255];
  logic [127:0] ks10 [0:15];
  logic [127:0] ks14 [0:15];

  bit           sel;
  logic [3:0]   o_rk;
  logic [127:0] o_pt;
  logic         o_v, o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  aes_dec_round_ctrl #(.NR(10)) u_dut10 (
    .clk(clk), .rst(rst), .start(start10), .ct_i(ct), .rk_idx(rk_idx10),
    .rk_i(rk10), .isb_o(isbo10), .isb_i(isbi10), .busy(busy10),
    .pt_o(pt10), .pt_valid(v10), .pt_ready(pt_ready)
  );

  aes_dec_round_ctrl #(.NR(14)) u_dut14 (
    .clk(clk), .rst(rst), .start(start14), .ct_i(ct), .rk_idx(rk_idx14),
    .rk_i(rk14), .isb_o(isbo14), .isb_i(isbi14), .busy(busy14),
    .pt_o(pt14), .pt_valid(v14), .pt_ready(pt_ready)
  );

  always #5 clk = ~clk;

  // Key store and inverse S-box bank: same-cycle combinational return
  assign rk10 = ks10[rk_idx10];
  assign rk14 = ks14[rk_idx14];
  always_comb begin
    isbi10 = '0;
    isbi14 = '0;
    for (int b = 0; b < 16; b++) begin
      isbi10[127-8*b -: 8] = isbox[isbo10[127-8*b -: 8]];
      isbi14[127-8*b -: 8] = isbox[isbo14[127-8*b -: 8]];
    end
  end

  // Observation mux for the instance under test
  always_comb begin
    o_rk   = sel ? rk_idx14 : rk_idx10;
    o_pt   = sel ? pt14 : pt10;
    o_v    = sel ? v14 : v10;
    o_busy = sel ? busy14 : busy10;
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // Builds S-box from GF(2^8) inverse plus affine map, then its inverse
  task automatic init_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Standard key expansion; key left-aligned in 256 bits, nk = 4 or 8
  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w[0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nk == 4) ks10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         ks14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Byte-array inverse cipher using the current key-store contents
  function automatic logic [127:0] model_dec(input logic [127:0] c_in, input int nr);
    logic [7:0]   s[16], t[16];
    logic [127:0] k, res;
    k = (nr == 10) ? ks10[nr] : ks14[nr];
    for (int i = 0; i < 16; i++) s[i] = c_in[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rd = nr - 1; rd >= 0; rd--) begin
      k = (nr == 10) ? ks10[rd] : ks14[rd];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = isbox[s[r+4*((c-r+4)%4)]] ^ k[127-8*(r+4*c) -: 8];
      for (int c = 0; c < 4; c++) begin
        if (rd > 0) begin
          s[4*c]   = gm(t[4*c],8'h0e) ^ gm(t[4*c+1],8'h0b) ^ gm(t[4*c+2],8'h0d) ^ gm(t[4*c+3],8'h09);
          s[4*c+1] = gm(t[4*c],8'h09) ^ gm(t[4*c+1],8'h0e) ^ gm(t[4*c+2],8'h0b) ^ gm(t[4*c+3],8'h0d);
          s[4*c+2] = gm(t[4*c],8'h0d) ^ gm(t[4*c+1],8'h09) ^ gm(t[4*c+2],8'h0e) ^ gm(t[4*c+3],8'h0b);
          s[4*c+3] = gm(t[4*c],8'h0b) ^ gm(t[4*c+1],8'h0d) ^ gm(t[4*c+2],8'h09) ^ gm(t[4*c+3],8'h0e);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input bit s, input logic v);
    if (s) start14 = v;
    else   start10 = v;
  endtask

  // One decryption with pt_ready=1; optional extra start pulse at cycle inj
  task automatic dec(input bit s, input logic [127:0] c_in, input logic [127:0] expv,
                     input int inj, input string tag);
    int nr = s ? 14 : 10;
    sel = s; ct = c_in; pt_ready = 1'b1;
    drive_start(s, 1'b1);
    #1;
    chk($sformatf("%s_rk_c0", tag), 128'(o_rk), 128'(nr));
    tick();
    for (int c = 1; c <= nr; c++) begin
      if (c == inj) begin
        ct = ~c_in;
        drive_start(s, 1'b1);
      end else begin
        drive_start(s, 1'b0);
      end
      chk($sformatf("%s_rk_c%0d", tag, c), 128'(o_rk), 128'(nr - c));
      chk($sformatf("%s_valid_c%0d", tag, c), 128'(o_v), 128'(0));
      chk($sformatf("%s_busy_c%0d", tag, c), 128'(o_busy), 128'(1));
      tick();
    end
    drive_start(s, 1'b0);
    chk($sformatf("%s_valid_latency", tag), 128'(o_v), 128'(1));
    chk($sformatf("%s_pt", tag), o_pt, expv);
    tick();
    chk($sformatf("%s_valid_drop", tag), 128'(o_v), 128'(0));
    chk($sformatf("%s_busy_drop", tag), 128'(o_busy), 128'(0));
  endtask

  initial begin
    logic [127:0] exp_pt, cap, rct;
    logic [255:0] rkey;
    int n;
    rst = 1'b1; start10 = 1'b0; start14 = 1'b0; pt_ready = 1'b0; ct = '0; sel = 1'b0;
    init_tables();
    tick(); tick();

    // Reset state
    chk("rst_busy", 128'(busy10), 128'(0));
    chk("rst_valid", 128'(v10), 128'(0));
    chk("rst_pt", pt10, 128'h0);
    chk("rst_rk10", 128'(rk_idx10), 128'(10));
    chk("rst_rk14", 128'(rk_idx14), 128'(14));
    rst = 1'b0;
    tick();

    // FIPS-197 Appendix B
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    dec(1'b0, 128'h3925841d02dc09fbdc118597196a0b32,
        128'h3243f6a8885a308d313198a2e0370734, -1, "appB");

    // FIPS-197 C.1
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    dec(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'h00112233445566778899aabbccddeeff, -1, "c1");

    // Start while busy: second start at cycle 5 ignored, nothing queued
    dec(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'h00112233445566778899aabbccddeeff, 5, "busy_start");
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("no_second_valid_%0d", i), 128'(v10), 128'(0));
    end
    chk("no_second_busy", 128'(busy10), 128'(0));

    // Backpressure with random vector; start pulses while held in DONE ignored
    sel = 1'b0;
    rkey = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    expand(rkey, 4);
    rct = {$urandom, $urandom, $urandom, $urandom};
    exp_pt = model_dec(rct, 10);
    ct = rct; pt_ready = 1'b0; start10 = 1'b1;
    tick();
    start10 = 1'b0;
    n = 0;
    while (!v10 && n < 40) begin
      tick();
      n++;
    end
    chk("bp_latency", 128'(n), 128'(10));
    chk("bp_pt", pt10, exp_pt);
    cap = pt10;
    for (int i = 0; i < 20; i++) begin
      start10 = i[0];
      tick();
      chk($sformatf("bp_hold_valid_%0d", i), 128'(v10), 128'(1));
      chk($sformatf("bp_hold_pt_%0d", i), pt10, exp_pt);
      chk($sformatf("bp_hold_busy_%0d", i), 128'(busy10), 128'(1));
    end
    start10 = 1'b0; pt_ready = 1'b1;
    tick();
    chk("bp_release_valid", 128'(v10), 128'(0));
    chk("bp_release_busy", 128'(busy10), 128'(0));
    chk("bp_pt_held_idle", pt10, cap);

    // Reset mid-run at cycle 6, then C.1 still decrypts
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; start10 = 1'b1;
    tick();
    start10 = 1'b0;
    for (int i = 1; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 128'(busy10), 128'(0));
    chk("midrst_valid", 128'(v10), 128'(0));
    chk("midrst_rk", 128'(rk_idx10), 128'(10));
    chk("midrst_pt", pt10, 128'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("midrst_no_valid_%0d", i), 128'(v10), 128'(0));
    end
    dec(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'h00112233445566778899aabbccddeeff, -1, "c1_after_rst");

    // FIPS-197 C.3 on the NR=14 instance
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    dec(1'b1, 128'h8ea2b7ca516745bfeafc49904b496089,
        128'h00112233445566778899aabbccddeeff, -1, "c3");

    // Randomized vectors against the byte-level model
    for (int k = 0; k < 6; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rct  = {$urandom, $urandom, $urandom, $urandom};
      expand({rkey[255:128], 128'h0}, 4);
      dec(1'b0, rct, model_dec(rct, 10), -1, $sformatf("rnd10_%0d", k));
      expand(rkey, 8);
      dec(1'b1, rct, model_dec(rct, 14), -1, $sformatf("rnd14_%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
